// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with flush, bubble output and a saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN for the 2-entry skid buffer with registered InReady.
module pipe_stage_reg #(
  parameter int unsigned          WIDTH  = 32,
  parameter logic [WIDTH-1:0]     BUBBLE = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [15:0]      StallCount
);

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`else
  typedef enum logic {EMPTY, ONE} state_t;
`endif

  state_t           state, stateNext;
  logic [WIDTH-1:0] main, mainNext;
  logic             inXfer, outXfer;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid, skidNext;
  logic             inReadyQ;

  // Ready is a flop so OutReady never reaches InReady combinationally.
  assign InReady = inReadyQ;
`else
  assign InReady = !OutValid || OutReady;
`endif

  assign OutValid = (state != EMPTY);
  assign OutData  = OutValid ? main : BUBBLE;
  assign inXfer   = InValid && InReady;
  assign outXfer  = OutValid && OutReady;

  always_comb begin
    stateNext = state;
    mainNext  = main;
`ifdef PIPE_STAGE_REG_SKID_EN
    skidNext  = skid;
`endif
    case (state)
      EMPTY: begin
        if (inXfer) begin
          stateNext = ONE;
          mainNext  = InData;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          mainNext = InData;
`ifdef PIPE_STAGE_REG_SKID_EN
        end else if (inXfer) begin
          stateNext = TWO;
          skidNext  = InData;
`endif
        end else if (outXfer) begin
          stateNext = EMPTY;
        end
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      TWO: begin
        if (outXfer) begin
          stateNext = ONE;
          mainNext  = skid;
        end
      end
`endif
      default: stateNext = EMPTY;
    endcase
    // Squash wins over any input offered in the same cycle.
    if (Flush) stateNext = EMPTY;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= EMPTY;
      main  <= BUBBLE;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid     <= BUBBLE;
      inReadyQ <= 1'b1;
`endif
    end else begin
      state <= stateNext;
      main  <= mainNext;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid     <= skidNext;
      inReadyQ <= (stateNext != TWO);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      StallCount <= '0;
    else if (OutValid && !OutReady && StallCount != 16'hFFFF)
      StallCount <= StallCount + 16'd1;
  end

endmodule
